// File: rtl/capture_trigger_if.sv
// ADC sample stream into capture_trigger: one 12-bit sample per cycle
// in which adc_valid is high.
interface capture_trigger_if;
   logic [11:0] adc_data;
   logic        adc_valid;

   modport master (output adc_data, output adc_valid);
   modport slave  (input  adc_data, input  adc_valid);
endinterface

// File: rtl/capture_trigger.sv
// capture_trigger: triggered 256-sample acquisition buffer feeding the
// display renderer. Samples go into a circular buffer. After PRETRIG
// pre-trigger samples, the block waits for a level crossing and then
// collects 255-PRETRIG post-trigger samples. The frame is published,
// oldest sample first, only while vblnk is high.
// Optional feature: define TRIG_AUTO_EN to force a trigger after
// AUTO_TIMEOUT valid samples spent in ARMED.
module capture_trigger #(
   parameter int PRETRIG      = 32,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   capture_trigger_if.slave     adc,
   input  logic [11:0]          trig_level,
   input  logic                 trig_slope,
   input  logic                 run,
   input  logic                 vblnk,
   output logic [11:0]          data_display [0:255],
   output logic                 armed,
   output logic                 frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ARMED,
      S_POST,
      S_HOLD
   } state_t;

   localparam logic [7:0] PRE_LAST  = 8'(PRETRIG - 1);
   localparam logic [7:0] POST_LAST = 8'(254 - PRETRIG);
   localparam logic [7:0] PRE_OFS   = 8'(PRETRIG);

   if (PRETRIG < 1 || PRETRIG > 254 || AUTO_TIMEOUT < 1) begin : g_bad_param
      $error("capture_trigger: PRETRIG must be 1..254 and AUTO_TIMEOUT >= 1");
   end

   state_t      state;
   state_t      state_next;
   logic [7:0]  wr_ptr;
   logic [7:0]  trig_ptr;
   logic [7:0]  pre_cnt;
   logic [7:0]  post_cnt;
   logic [11:0] prev;
   logic [11:0] mem [0:255];
   logic [7:0]  rd_base;

   logic        sample;
   logic        level_hit;
   logic        trig_hit;
   logic        publish;

`ifdef TRIG_AUTO_EN
   localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);
   logic [AUTO_W-1:0] auto_cnt;
   logic              auto_hit;

   assign auto_hit = (auto_cnt == AUTO_LAST);

   // Samples spent waiting in ARMED; cleared whenever ARMED is left or not yet entered
   always_ff @(posedge clk) begin
      if (rst) begin
         auto_cnt <= '0;
      end else if (state != S_ARMED || state_next != S_ARMED) begin
         auto_cnt <= '0;
      end else if (adc.adc_valid) begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end
`endif

   assign armed   = (state == S_ARMED);
   assign rd_base = trig_ptr - PRE_OFS;

   // Live level-crossing detector against the previous accepted sample
   always_comb begin
      level_hit = 1'b0;
      if (trig_slope) begin
         level_hit = (prev > trig_level) && (adc.adc_data <= trig_level);
      end else begin
         level_hit = (prev < trig_level) && (adc.adc_data >= trig_level);
      end
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      state_next = state;
      sample     = 1'b0;
      trig_hit   = 1'b0;
      publish    = 1'b0;

      if (state == S_PRE || state == S_ARMED || state == S_POST) begin
         sample = adc.adc_valid;
      end
      if (state == S_ARMED && adc.adc_valid) begin
`ifdef TRIG_AUTO_EN
         trig_hit = level_hit || auto_hit;
`else
         trig_hit = level_hit;
`endif
      end
      if (state == S_HOLD && vblnk) begin
         publish = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (run) state_next = S_PRE;
         end
         S_PRE: begin
            if (!run) state_next = S_IDLE;
            else if (sample && pre_cnt == PRE_LAST) state_next = S_ARMED;
         end
         S_ARMED: begin
            if (!run) state_next = S_IDLE;
            else if (trig_hit) state_next = S_POST;
         end
         S_POST: begin
            if (sample && post_cnt == POST_LAST) state_next = S_HOLD;
         end
         S_HOLD: begin
            if (vblnk) state_next = run ? S_PRE : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Write pointer, previous sample, phase counters and trigger position
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         prev     <= '0;
         pre_cnt  <= '0;
         post_cnt <= '0;
         trig_ptr <= '0;
      end else begin
         if (sample) begin
            wr_ptr <= wr_ptr + 8'd1;
            prev   <= adc.adc_data;
         end
         if (state_next == S_PRE && state != S_PRE) begin
            pre_cnt <= '0;
         end else if (state == S_PRE && sample) begin
            pre_cnt <= pre_cnt + 8'd1;
         end
         if (trig_hit) begin
            trig_ptr <= wr_ptr;
            post_cnt <= '0;
         end else if (state == S_POST && sample) begin
            post_cnt <= post_cnt + 8'd1;
         end
      end
   end

   // Circular sample store; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (sample) begin
         mem[wr_ptr] <= adc.adc_data;
      end
   end

   // Blank-gated publish, rotated so index 0 is the oldest sample of the frame
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 256; i++) begin
            data_display[i] <= '0;
         end
      end else if (publish) begin
         for (int unsigned i = 0; i < 256; i++) begin
            data_display[i] <= mem[rd_base + 8'(i)];
         end
      end
   end

   // Completion strobe for the cycle following a publish
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= publish;
      end
   end

endmodule

// File: tb/tb_capture_trigger.sv
// Testbench for capture_trigger: directed waveforms with hand-derived
// expected frames queued ahead of each publish; a monitor pops and
// compares one frame per frame_done pulse.
module tb_capture_trigger;
   localparam int PRETRIG      = 32;
   localparam int AUTO_TIMEOUT = 64;

   typedef logic [255:0][11:0] frame_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] trig_level;
   logic        trig_slope;
   logic        run;
   logic        vblnk;
   logic [11:0] data_display [0:255];
   logic        armed;
   logic        frame_done;

   capture_trigger_if adc ();

   capture_trigger #(
      .PRETRIG      (PRETRIG),
      .AUTO_TIMEOUT (AUTO_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .adc          (adc),
      .trig_level   (trig_level),
      .trig_slope   (trig_slope),
      .run          (run),
      .vblnk        (vblnk),
      .data_display (data_display),
      .armed        (armed),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   frame_t exp_q [$];
   int     checks      = 0;
   int     errors      = 0;
   int     frames_seen = 0;
   int     pushes      = 0;
   logic   fd_prev     = 1'b0;
   frame_t zero_frame  = '0;
   frame_t disp_ref;
   frame_t f;

   // Ramp: 0x10 per sample, 12-bit wrap
   function automatic logic [11:0] ramp(input int k);
      return 12'(k * 16);
   endfunction

   // Triangle with period 256: up 0x000..0x7F0, then down 0x7F0..0x000
   function automatic logic [11:0] tri_w(input int k);
      int m;
      m = k % 256;
      if (m < 128) return 12'(m * 16);
      return 12'((255 - m) * 16);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_disp(input string name, input frame_t ref_f);
      int bad;
      int first;
      bad   = 0;
      first = -1;
      for (int i = 0; i < 256; i++) begin
         if (data_display[i] !== ref_f[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d entries differ, first [%0d] got 0x%0h expected 0x%0h",
                  name, bad, first, data_display[first], ref_f[first]);
      end
   endtask

   task automatic send(input logic [11:0] v);
      adc.adc_data  = v;
      adc.adc_valid = 1'b1;
      @(posedge clk);
      #1;
      adc.adc_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      adc.adc_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_frame(input frame_t ef);
      exp_q.push_back(ef);
      pushes++;
   endtask

   // Monitor: every frame_done pulse must match the oldest queued frame
   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         frames_seen++;
         if (fd_prev === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_width: got high for 2+ cycles expected 1");
         end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got frame_done expected none");
         end else begin
            f = exp_q.pop_front();
            chk_disp("frame_content", f);
         end
      end
      fd_prev <= frame_done;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      run           = 1'b0;
      vblnk         = 1'b0;
      trig_level    = 12'h800;
      trig_slope    = 1'b0;
      adc.adc_data  = '0;
      adc.adc_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_armed", 32'(armed), 32'd0);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      chk_disp("reset_display", zero_frame);
      rst = 1'b0;

      // Rising ramp: trigger at k=128 (0x800), frame is k=96..351
      run = 1'b1;
      idle(1);
      for (int k = 0; k < 352; k++) begin
         send(ramp(k));
         if (k == 30)  chk("pre_not_yet_armed", 32'(armed), 32'd0);
         if (k == 31)  chk("armed_after_pretrig", 32'(armed), 32'd1);
         if (k == 127) chk("armed_before_hit", 32'(armed), 32'd1);
         if (k == 128) chk("armed_falls_on_hit", 32'(armed), 32'd0);
      end
      run = 1'b0;
      for (int k = 0; k < 256; k++) f[k] = ramp(96 + k);
      expect_frame(f);
      // Samples offered in HOLD must be dropped (wr_ptr now points at the oldest frame entry)
      repeat (1000) send(12'hFFF);
      chk_disp("hold_display_stable", zero_frame);
      chk("no_frame_before_blank", 32'(frames_seen), 32'd0);
      vblnk = 1'b1;
      idle(1);
      vblnk = 1'b0;
      chk("frame_done_after_blank", 32'(frame_done), 32'd1);
      chk("ramp_idx0", 32'(data_display[0]), 32'h600);
      chk("ramp_idx32", 32'(data_display[32]), 32'h800);
      // 0x600 + 255*0x10 = 0x15F0, 12-bit wrap gives 0x5F0
      chk("ramp_idx255", 32'(data_display[255]), 32'h5F0);
      idle(1);
      chk("frame_done_one_cycle", 32'(frame_done), 32'd0);

      // Falling slope on triangle: hit at k=191 (0x400, prev 0x410); run dropped in POST
      trig_slope = 1'b1;
      trig_level = 12'h400;
      vblnk      = 1'b1;
      run        = 1'b1;
      idle(1);
      for (int k = 0; k < 256; k++) f[k] = tri_w(159 + k);
      expect_frame(f);
      disp_ref = f;
      for (int k = 0; k < 415; k++) begin
         send(tri_w(k));
         if (k == 250) run = 1'b0;
      end
      idle(1);
      chk("publish_edge_after_hold_entry", 32'(frame_done), 32'd1);
      chk("falling_idx32_le_level", 32'(data_display[32] <= 12'h400), 32'd1);
      chk("falling_idx31_gt_level", 32'(data_display[31] > 12'h400), 32'd1);
      idle(1);
      vblnk = 1'b0;
      chk("falling_frame_seen", 32'(frames_seen), 32'd2);

      // Abort in ARMED: display must keep the falling frame
      trig_slope = 1'b0;
      trig_level = 12'h800;
      run        = 1'b1;
      idle(1);
      repeat (40) send(12'h100);
      chk("abort_was_armed", 32'(armed), 32'd1);
      run = 1'b0;
      idle(1);
      chk("abort_left_armed", 32'(armed), 32'd0);
      vblnk = 1'b1;
      idle(2);
      vblnk = 1'b0;
      repeat (20) send(12'h100);
      chk_disp("abort_display_unchanged", disp_ref);

      // Flat input: only the auto trigger can complete a frame
      run = 1'b1;
      idle(1);
      repeat (PRETRIG + AUTO_TIMEOUT - 1) send(12'h100);
      chk("auto_still_armed", 32'(armed), 32'd1);
      send(12'h100);
`ifdef TRIG_AUTO_EN
      chk("auto_timeout_trigger", 32'(armed), 32'd0);
`else
      chk("no_auto_trigger", 32'(armed), 32'd1);
`endif
      repeat (255 - PRETRIG) send(12'h100);
`ifdef TRIG_AUTO_EN
      for (int k = 0; k < 256; k++) f[k] = 12'h100;
      expect_frame(f);
      disp_ref = f;
`endif
      run   = 1'b0;
      vblnk = 1'b1;
      idle(1);
      vblnk = 1'b0;
`ifdef TRIG_AUTO_EN
      chk("auto_frame_done", 32'(frame_done), 32'd1);
`else
      chk("auto_no_frame_done", 32'(frame_done), 32'd0);
`endif
      idle(2);
      chk_disp("auto_display", disp_ref);

      // Reset mid-POST (ramp hit at k=128, POST by k=199)
      trig_slope = 1'b0;
      trig_level = 12'h800;
      run        = 1'b1;
      idle(1);
      for (int k = 0; k < 200; k++) send(ramp(k));
      chk("in_post_before_reset", 32'(armed), 32'd0);
      rst = 1'b1;
      run = 1'b0;
      idle(1);
      rst = 1'b0;
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk_disp("rst_display_cleared", zero_frame);
      for (int k = 0; k < 300; k++) begin
         vblnk = ((k % 16) >= 8);
         send(ramp(k));
      end
      vblnk = 1'b0;
      idle(5);
      chk_disp("rst_display_still_clear", zero_frame);
      chk("frames_seen_total", 32'(frames_seen), 32'(pushes));
      chk("expected_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
